bf_stdout_uart: RTL and testbench
=================================

// Module: bf_stdout_uart
// PURPOSE
//  Consumer end of the processor's stdout/stdout_en output. Buffers emitted characters in a
//  FIFO and serialises them as 8N1 UART frames on tx. Throttles the processor through cpu_en
//  (wired to the core's en input) so that no character is lost.
// PARAMETERS
//  CLK_DIV     104  clk cycles per UART bit (>=2)
//  FIFO_DEPTH  16   character buffer entries (power of 2, >=4)
// PORTS
//  clk         in   1  clock
//  reset       in   1  reset, synchronous, active-high
//  stdout      in   8  character from core
//  stdout_en   in   1  core output strobe; held high while the core is stalled
//  cpu_en      out  1  high = FIFO can accept; drives core en
//  tx          out  1  UART serial line, idle high
//  busy        out  1  frame in progress or FIFO non-empty
//  overflow    out  1  sticky: a character was dropped
// BEHAVIOUR
//  Reset: tx=1, cpu_en=1, busy=0, overflow=0, FIFO empty, stdout_en_q=0, FSM=IDLE.
//   Reset mid-frame aborts the frame: tx=1 after the reset edge, FIFO flushed.
//  Capture: push = stdout_en & ~stdout_en_q (rising edge only), so a strobe held high through
//   a stall is captured once. Two '.' in sequence produce two edges, because the core drops
//   stdout_en in between.
//  Push sampled at edge k: entry visible (count+1) after edge k.
//  cpu_en = (count < FIFO_DEPTH-1), combinational from registered count. One-slot margin
//   covers the core's one-cycle en response.
//  Push while count==FIFO_DEPTH: data dropped, overflow<=1 until reset.
//  Simultaneous push and pop: count unchanged, data order preserved.
//  FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> IDLE.
//   IDLE: if FIFO non-empty, pop into shift reg, go to START. tx<=0 on the same edge, so the
//    start bit begins 1 cycle after the entry becomes visible.
//   Every bit state holds tx for exactly CLK_DIV cycles. Baud counter is ceil(log2(CLK_DIV))
//    bits and reloads at each bit boundary.
//   DATA: LSB first, 3-bit index, exits after bit 7.
//   STOP: tx=1 for CLK_DIV cycles. At the STOP->IDLE edge, a non-empty FIFO is popped
//    directly into START (no idle gap).
//  Frame length is 10*CLK_DIV cycles, or 11*CLK_DIV with parity.
//  busy = (state!=IDLE) | (count!=0).
// CONFIGURATION
//  BF_STDOUT_PARITY_EN defined: a PARITY state follows DATA and sends even parity (^data).
//   Frame is 8E1.
//  BF_STDOUT_PARITY_EN undefined: no PARITY state, frame is 8N1. All other behaviour is
//   identical.
// STRUCTURE
//  bf_pkg: UART state encoding (IDLE/START/DATA/PARITY/STOP), BF_CHAR_W=8, UART_DATA_BITS=8.
//  Sub-module bf_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count, registered storage,
//   drop on push-when-full, passes pop-when-empty through as a no-op.
//  Top level: edge detect, overflow flag, cpu_en, UART FSM, baud counter.
// TESTING (CLK_DIV=4, FIFO_DEPTH=16)
//  T1: single 'A' (0x41) strobe -> tx low 4 cyc, then 1,0,0,0,0,0,1,0 each 4 cyc, then stop
//   high 4 cyc. Start bit begins 2 cyc after the strobe edge; busy falls after stop.
//  T2: stdout_en held high 10 cyc with 'B' -> exactly one frame, FIFO count peaks at 1.
//  T3: 20 chars, one every 4 cyc, core stalled whenever cpu_en=0 -> cpu_en low at count 15,
//   all 20 chars leave on tx in order, overflow stays 0, frames back-to-back.
//  T4: ignore cpu_en, push 18 chars with no UART drain time -> overflow=1,
//   excess chars dropped, first 16-17 chars intact and in order.
//  T5: reset asserted mid-DATA of 'Z' with 3 chars queued -> tx=1 next cycle, busy=0,
//   count=0, no further frames.
//  T6 (BF_STDOUT_PARITY_EN): 'A' (0x41) -> parity bit 0. 'C' (0x43) -> parity bit 1.
//   Frame is 44 cyc.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the stdout UART: character width, data-bit count and UART state encoding.
package bf_pkg;

  localparam int unsigned BF_CHAR_W      = 8;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W      = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [BF_CHAR_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// Synchronous FIFO: push when full is dropped, pop when empty is a no-op.
module bf_sync_fifo
  import bf_pkg::*;
#(
  parameter int unsigned WIDTH = BF_CHAR_W,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/bf_stdout_uart.sv
// Buffers core stdout characters and sends them as UART frames, throttling the core via cpu_en.
// Define BF_STDOUT_PARITY_EN for 8E1 frames (even parity bit after data); default is 8N1.
module bf_stdout_uart
  import bf_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 104,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BF_CHAR_W-1:0] stdout,
  input  logic                 stdout_en,
  output logic                 cpu_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(UART_DATA_BITS - 1);
  localparam logic [CNT_W-1:0]     CPU_LIMIT = CNT_W'(FIFO_DEPTH - 1);

  logic                 stdout_en_q, stdout_en_d;
  logic                 overflow_q, overflow_d;
  uart_state_e          state_q, state_d;
  logic                 tx_q, tx_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [BF_CHAR_W-1:0] data_q, data_d;

  logic                 push, pop;
  logic                 fifo_full, fifo_empty;
  logic [BF_CHAR_W-1:0] fifo_rd;
  logic [CNT_W-1:0]     fifo_count;
  logic                 baud_done;
  logic [BIT_IDX_W-1:0] next_idx;

  bf_sync_fifo #(
    .WIDTH (BF_CHAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (stdout),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A strobe held high through a core stall is one character, so only the rising edge pushes.
  assign push     = stdout_en & ~stdout_en_q;
  assign cpu_en   = (fifo_count < CPU_LIMIT);
  assign busy     = (state_q != ST_IDLE) | (fifo_count != '0);
  assign tx       = tx_q;
  assign overflow = overflow_q;

  always_comb begin
    stdout_en_d = stdout_en;
    overflow_d  = overflow_q | (push & fifo_full);
    state_d     = state_q;
    tx_d        = tx_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    data_d      = data_q;
    pop         = 1'b0;
    baud_done   = (baud_q == BAUD_LAST);
    next_idx    = bit_idx_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_rd;
          state_d = ST_START;
          tx_d    = 1'b0;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_d   = ST_DATA;
          tx_d      = data_q[0];
          bit_idx_d = '0;
          baud_d    = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == LAST_BIT) begin
`ifdef BF_STDOUT_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = even_parity(data_q);
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = next_idx;
            tx_d      = data_q[next_idx];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef BF_STDOUT_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued characters go out back-to-back.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_rd;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stdout_en_q <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      tx_q        <= 1'b1;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
    end else begin
      stdout_en_q <= stdout_en_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_bf_stdout_uart.sv
// Self-checking bench for bf_stdout_uart: queue-based line model plus directed scenarios.
module tb_bf_stdout_uart;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 16;
`ifdef BF_STDOUT_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] stdout = '0;
  logic       stdout_en = 1'b0;
  logic       cpu_en, tx, busy, overflow;

  always #5 clk = ~clk;

  bf_stdout_uart #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stdout    (stdout),
    .stdout_en (stdout_en),
    .cpu_en    (cpu_en),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  // Model: characters queue up; whenever the line has nothing left to send, the next
  // character becomes a frame of bit values, each held for CLK_DIV cycles.
  byte unsigned m_fifo[$];
  byte unsigned m_sent[$];
  bit           m_line[$];
  bit           m_en_prev = 1'b0;
  bit           m_ovf     = 1'b0;
  bit           m_active  = 1'b0;
  bit           m_tx      = 1'b1;
  bit           m_valid   = 1'b0;
  int           m_peak    = 0;

  function automatic void push_frame(input byte unsigned c);
    bit fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(c[i]);
`ifdef BF_STDOUT_PARITY_EN
    fb.push_back(^c);
`endif
    fb.push_back(1'b1);
    foreach (fb[i])
      for (int r = 0; r < int'(CLK_DIV); r++) m_line.push_back(fb[i]);
  endfunction

  always @(posedge clk) begin : model_step
    int           pre;
    bit           psh;
    byte unsigned c;
    if (reset) begin
      m_fifo.delete();
      m_line.delete();
      m_sent.delete();
      m_en_prev = 1'b0;
      m_ovf     = 1'b0;
      m_active  = 1'b0;
      m_tx      = 1'b1;
      m_peak    = 0;
      m_valid   = 1'b1;
    end else begin
      pre = m_fifo.size();
      psh = stdout_en && !m_en_prev;
      if (m_line.size() == 0 && pre > 0) begin
        c = m_fifo.pop_front();
        m_sent.push_back(c);
        push_frame(c);
      end
      if (psh) begin
        if (pre == int'(FIFO_DEPTH)) m_ovf = 1'b1;
        else                         m_fifo.push_back(stdout);
      end
      m_en_prev = stdout_en;
      if (m_line.size() > 0) begin
        m_tx     = m_line.pop_front();
        m_active = 1'b1;
      end else begin
        m_tx     = 1'b1;
        m_active = 1'b0;
      end
      if (m_fifo.size() > m_peak) m_peak = m_fifo.size();
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("tx",       tx,       m_tx);
      check("busy",     busy,     m_active || (m_fifo.size() != 0));
      check("cpu_en",   cpu_en,   m_fifo.size() < int'(FIFO_DEPTH) - 1);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    stdout_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic strobe(input byte unsigned c, input int hold);
    stdout    = c;
    stdout_en = 1'b1;
    repeat (hold) @(negedge clk);
    stdout_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (!busy && m_line.size() == 0 && m_fifo.size() == 0) break;
      @(negedge clk);
    end
    check({name, "_drain"}, (i < 3000), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  logic [0:47] rtx, rbusy;

  task automatic record(input byte unsigned c);
    @(negedge clk);
    stdout    = c;
    stdout_en = 1'b1;
    @(negedge clk);
    stdout_en = 1'b0;
    for (int i = 0; i < 48; i++) begin
      rtx[i]   = tx;
      rbusy[i] = busy;
      @(negedge clk);
    end
  endtask

  logic [0:47] exp_a;
  bit          saw_stall;
  int          w;

  initial begin
`ifdef BF_STDOUT_PARITY_EN
    exp_a = 48'b1_0000_1111_0000_0000_0000_0000_0000_1111_0000_0000_1111_111;
`else
    exp_a = 48'b1_0000_1111_0000_0000_0000_0000_0000_1111_0000_1111_1111111;
`endif

    // Reset state
    do_reset();
    check("rst_tx",       tx,       1'b1);
    check("rst_cpu_en",   cpu_en,   1'b1);
    check("rst_busy",     busy,     1'b0);
    check("rst_overflow", overflow, 1'b0);

    // T1: single 'A'
    record(8'h41);
    check("t1_waveform", rtx, exp_a);
    check("t1_busy_last_stop", rbusy[4*FRAME_BITS],   1'b1);
    check("t1_busy_after",     rbusy[4*FRAME_BITS+1], 1'b0);
    drain("t1");

    // T2: strobe held 10 cycles
    do_reset();
    strobe(8'h42, 10);
    drain("t2");
    check("t2_frames", m_sent.size(), 1);
    check("t2_char",   m_sent[0],     8'h42);
    check("t2_peak",   m_peak,        1);

    // T3: 20 chars, core stalls on cpu_en
    do_reset();
    saw_stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      w = 0;
      while (!cpu_en && w < 500) begin
        saw_stall = 1'b1;
        @(negedge clk);
        w++;
      end
      check("t3_stall_bound", (w < 500), 1'b1);
      strobe(8'(8'h30 + i), 1);
      repeat (2) @(negedge clk);
    end
    drain("t3");
    check("t3_count", m_sent.size(), 20);
    for (int i = 0; i < 20; i++) check("t3_order", m_sent[i], 8'(8'h30 + i));
    check("t3_peak",  m_peak,    15);
    check("t3_stall", saw_stall, 1'b1);
    check("t3_ovf",   overflow,  1'b0);

    // T4: 18 pushes ignoring cpu_en
    do_reset();
    for (int i = 0; i < 18; i++) strobe(8'(8'h61 + i), 1);
    check("t4_model_ovf", m_ovf,    1'b1);
    check("t4_ovf",       overflow, 1'b1);
    drain("t4");
    check("t4_count", m_sent.size(), 17);
    for (int i = 0; i < 17; i++) check("t4_order", m_sent[i], 8'(8'h61 + i));
    check("t4_ovf_sticky", overflow, 1'b1);

    // T5: reset mid-DATA of 'Z' with 3 queued
    do_reset();
    strobe(8'h5A, 1);
    strobe(8'h61, 1);
    strobe(8'h62, 1);
    strobe(8'h63, 1);
    check("t5_queued", m_fifo.size(), 3);
    check("t5_busy_pre", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_tx",     tx,     1'b1);
    check("t5_busy",   busy,   1'b0);
    check("t5_cpu_en", cpu_en, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) check("t5_tx_idle", tx, 1'b1);
    end
    check("t5_no_frames", m_sent.size(), 0);
    check("t5_busy_end",  busy,          1'b0);

`ifdef BF_STDOUT_PARITY_EN
    // T6: parity bit of 'C' and 44-cycle frame
    do_reset();
    record(8'h43);
    check("t6_start",  rtx[1],  1'b0);
    check("t6_parity", rtx[38], 1'b1);
    check("t6_stop",   rtx[42], 1'b1);
    check("t6_busy_last_stop", rbusy[44], 1'b1);
    check("t6_busy_after",     rbusy[45], 1'b0);
    drain("t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
